// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR stream source.
//  LFSR_MAX_W   : widest supported LFSR state
//  lfsr_state_e : stream control FSM states
//  lfsr_taps(w) : maximal-length Fibonacci tap mask for width w
//                 (bit k-1 set for tap k, zero for unsupported widths)
package lfsr_pkg;

  localparam int LFSR_MAX_W = 32;

  typedef enum logic {IDLE, RUN} lfsr_state_e;

  function automatic logic [31:0] tap_bit(int k);
    return 32'd1 << (k - 1);
  endfunction

  function automatic logic [31:0] lfsr_taps(int w);
    logic [31:0] m;
    m = '0;
    case (w)
      3:  m = tap_bit(3)  | tap_bit(2);
      4:  m = tap_bit(4)  | tap_bit(3);
      5:  m = tap_bit(5)  | tap_bit(3);
      6:  m = tap_bit(6)  | tap_bit(5);
      7:  m = tap_bit(7)  | tap_bit(6);
      8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
      9:  m = tap_bit(9)  | tap_bit(5);
      10: m = tap_bit(10) | tap_bit(7);
      11: m = tap_bit(11) | tap_bit(9);
      12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
      14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
      15: m = tap_bit(15) | tap_bit(14);
      16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: m = tap_bit(17) | tap_bit(14);
      18: m = tap_bit(18) | tap_bit(11);
      19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      20: m = tap_bit(20) | tap_bit(17);
      21: m = tap_bit(21) | tap_bit(19);
      22: m = tap_bit(22) | tap_bit(21);
      23: m = tap_bit(23) | tap_bit(18);
      24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25: m = tap_bit(25) | tap_bit(22);
      26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
      28: m = tap_bit(28) | tap_bit(25);
      29: m = tap_bit(29) | tap_bit(27);
      30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      31: m = tap_bit(31) | tap_bit(28);
      32: m = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational Fibonacci LFSR shift.
//  cur : current state (WIDTH bits)
//  adv : state after one shift; feedback enters at bit 0
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] adv
);

  localparam logic [WIDTH-1:0] MASK = WIDTH'(lfsr_taps(WIDTH));

  assign adv = {cur[WIDTH-2:0], ^(cur & MASK)};

endmodule

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR pseudo-random source with a valid/ready output stream.
// Each accepted beat advances the LFSR by OUT_W shifts in one cycle.
//  clk       : rising-edge clock
//  reset     : asynchronous active-low reset
//  en        : run enable (a pending beat is drained before stopping)
//  seed_load : load seed this cycle; overrides everything else
//  seed      : seed value (all-zero is replaced by 1)
//  out_valid : out_data holds an unconsumed beat
//  out_ready : consumer accepts the beat
//  out_data  : low OUT_W bits of the LFSR state
//  seed_err  : 1-cycle pulse after an all-zero seed was replaced
//  wrap      : 1-cycle pulse after a beat that returned the state to the seed
//  beat_cnt  : accepted beats since reset or seed load (wraps)
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OUT_W = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             seed_err,
  output logic             wrap,
  output logic [CNT_W-1:0] beat_cnt
);

  if (WIDTH < 3 || WIDTH > LFSR_MAX_W) begin : g_bad_width
    $fatal(1, "lfsr_stream: WIDTH must be 3..32");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
    $fatal(1, "lfsr_stream: OUT_W must be 1..WIDTH");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $fatal(1, "lfsr_stream: CNT_W must be 1..32");
  end

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] seed_fix;
  logic             fire;
  lfsr_state_e      fsm_q, fsm_d;

  // OUT_W single shifts chained into one beat advance.
  for (genvar g = 0; g < OUT_W; g++) begin : gen_step
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dst;
    if (g == 0) begin : g_first
      assign src = state;
    end else begin : g_next
      assign src = gen_step[g-1].dst;
    end
    lfsr_step #(.WIDTH(WIDTH)) u_step (.cur(src), .adv(dst));
  end
  assign adv = gen_step[OUT_W-1].dst;

  // The all-zero state would lock the LFSR, so it is never loaded.
  assign seed_fix  = (seed == '0) ? WIDTH'(1) : seed;
  assign out_valid = (fsm_q == RUN);
  assign fire      = out_valid & out_ready;
  assign out_data  = state[OUT_W-1:0];

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: if (en) fsm_d = RUN;
      RUN:  if (!en && (fire || !out_valid)) fsm_d = IDLE;
    endcase
    // A load always drops valid for at least one cycle.
    if (seed_load) fsm_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= WIDTH'(1);
      seed_reg <= WIDTH'(1);
      seed_err <= 1'b0;
      wrap     <= 1'b0;
      beat_cnt <= '0;
    end else if (seed_load) begin
      // A beat firing in the same cycle is treated as delivered; its advance is dropped.
      state    <= seed_fix;
      seed_reg <= seed_fix;
      seed_err <= (seed == '0);
      wrap     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      seed_err <= 1'b0;
      wrap     <= fire && (adv == seed_reg);
      if (fire) begin
        state    <= adv;
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed testbench for lfsr_stream with three configurations:
//  A: WIDTH=4,  OUT_W=1  (serial sequence, backpressure, seed load, drain)
//  B: WIDTH=4,  OUT_W=3  (multi-step beats, wrap period)
//  C: WIDTH=32, OUT_W=8  (long run against a reference model, async reset)
module tb_lfsr_stream;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        a_en = 0, a_ld = 0, a_ready = 0;
  logic [3:0]  a_seed = '0;
  logic        a_valid, a_serr, a_wrap;
  logic [0:0]  a_data;
  logic [31:0] a_cnt;

  logic        b_en = 0, b_ld = 0, b_ready = 0;
  logic [3:0]  b_seed = '0;
  logic        b_valid, b_serr, b_wrap;
  logic [2:0]  b_data;
  logic [31:0] b_cnt;

  logic        c_en = 0, c_ld = 0, c_ready = 0;
  logic [31:0] c_seed = '0;
  logic        c_valid, c_serr, c_wrap;
  logic [7:0]  c_data;
  logic [15:0] c_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_stream #(.WIDTH(4), .OUT_W(1), .CNT_W(32)) u_a (
    .clk(clk), .reset(reset), .en(a_en), .seed_load(a_ld), .seed(a_seed),
    .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
    .seed_err(a_serr), .wrap(a_wrap), .beat_cnt(a_cnt));

  lfsr_stream #(.WIDTH(4), .OUT_W(3), .CNT_W(32)) u_b (
    .clk(clk), .reset(reset), .en(b_en), .seed_load(b_ld), .seed(b_seed),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
    .seed_err(b_serr), .wrap(b_wrap), .beat_cnt(b_cnt));

  lfsr_stream #(.WIDTH(32), .OUT_W(8), .CNT_W(16)) u_c (
    .clk(clk), .reset(reset), .en(c_en), .seed_load(c_ld), .seed(c_seed),
    .out_valid(c_valid), .out_ready(c_ready), .out_data(c_data),
    .seed_err(c_serr), .wrap(c_wrap), .beat_cnt(c_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: 32-bit Fibonacci LFSR, taps 32,22,2,1, eight shifts per beat.
  function automatic logic [31:0] adv32x8(logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int k = 0; k < 8; k++) t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
    return t;
  endfunction

  task automatic test_reset();
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got %0b want 0", a_valid); end
    n_checks++; if (a_data !== 1'b1) begin n_fail++; $display("FAIL reset_a_data got %0h want 1", a_data); end
    n_checks++; if (a_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_a_cnt got %0d want 0", a_cnt); end
    n_checks++; if ({a_serr, a_wrap} !== 2'b00) begin n_fail++; $display("FAIL reset_a_pulses got %b want 00", {a_serr, a_wrap}); end
    n_checks++; if ({b_valid, b_serr, b_wrap} !== 3'b000) begin n_fail++; $display("FAIL reset_b_flags got %b want 000", {b_valid, b_serr, b_wrap}); end
    n_checks++; if (b_data !== 3'd1 || b_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_b_data_cnt got %0h/%0d want 1/0", b_data, b_cnt); end
    n_checks++; if ({c_valid, c_serr, c_wrap} !== 3'b000) begin n_fail++; $display("FAIL reset_c_flags got %b want 000", {c_valid, c_serr, c_wrap}); end
    n_checks++; if (c_data !== 8'h01 || c_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_c_data_cnt got %0h/%0d want 01/0", c_data, c_cnt); end
  endtask

  // Single-step sequence from state 1: 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8 -> LSBs.
  task automatic test_serial_w4();
    logic [0:14] lsb;
    lsb = 15'b100110101111000;
    a_en = 1; a_ready = 1;
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL serial_valid_before_en got %0b want 0", a_valid); end
    tick();
    for (int i = 0; i < 15; i++) begin
      n_checks++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL serial_valid beat %0d got %0b want 1", i, a_valid); end
      n_checks++; if (a_data !== lsb[i]) begin n_fail++; $display("FAIL serial_data beat %0d got %0b want %0b", i, a_data, lsb[i]); end
      n_checks++; if (a_wrap !== 1'b0) begin n_fail++; $display("FAIL serial_early_wrap beat %0d got %0b want 0", i, a_wrap); end
      tick();
    end
    a_ready = 0;
    n_checks++; if (a_wrap !== 1'b1) begin n_fail++; $display("FAIL serial_wrap got %0b want 1", a_wrap); end
    n_checks++; if (a_cnt !== 32'd15) begin n_fail++; $display("FAIL serial_cnt got %0d want 15", a_cnt); end
    n_checks++; if (a_data !== 1'b1) begin n_fail++; $display("FAIL serial_back_to_seed got %0b want 1", a_data); end
  endtask

  // Three shifts per beat: states 1,9,13,11,14 then 1 again -> low 3 bits.
  task automatic test_multi_step();
    logic [2:0] exp3 [5];
    exp3 = '{3'd1, 3'd1, 3'd5, 3'd3, 3'd6};
    b_en = 1; b_ready = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (b_valid !== 1'b1) begin n_fail++; $display("FAIL multi_valid beat %0d got %0b want 1", i, b_valid); end
      n_checks++; if (b_data !== exp3[i]) begin n_fail++; $display("FAIL multi_data beat %0d got %0d want %0d", i, b_data, exp3[i]); end
      n_checks++; if (b_wrap !== 1'b0) begin n_fail++; $display("FAIL multi_early_wrap beat %0d got %0b want 0", i, b_wrap); end
      tick();
    end
    b_en = 0;
    n_checks++; if (b_wrap !== 1'b1) begin n_fail++; $display("FAIL multi_wrap got %0b want 1", b_wrap); end
    n_checks++; if (b_cnt !== 32'd5) begin n_fail++; $display("FAIL multi_cnt got %0d want 5", b_cnt); end
    n_checks++; if (b_data !== 3'd1) begin n_fail++; $display("FAIL multi_back_to_seed got %0d want 1", b_data); end
    tick();
    n_checks++; if (b_wrap !== 1'b0) begin n_fail++; $display("FAIL multi_wrap_pulse got %0b want 0", b_wrap); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (a_valid !== 1'b1 || a_data !== 1'b1) begin n_fail++; $display("FAIL stall_hold cycle %0d got v=%0b d=%0b want 1/1", i, a_valid, a_data); end
      n_checks++; if (a_cnt !== 32'd15) begin n_fail++; $display("FAIL stall_cnt cycle %0d got %0d want 15", i, a_cnt); end
    end
    a_ready = 1;
    tick();
    a_ready = 0;
    n_checks++; if (a_data !== 1'b0 || a_cnt !== 32'd16) begin n_fail++; $display("FAIL stall_release got d=%0b cnt=%0d want 0/16", a_data, a_cnt); end
  endtask

  task automatic test_seed_zero();
    a_seed = 4'd0; a_ld = 1;
    tick();
    a_ld = 0;
    n_checks++; if (a_serr !== 1'b1) begin n_fail++; $display("FAIL zero_seed_err got %0b want 1", a_serr); end
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL zero_seed_valid got %0b want 0", a_valid); end
    n_checks++; if (a_cnt !== 32'd0 || a_data !== 1'b1) begin n_fail++; $display("FAIL zero_seed_state got cnt=%0d d=%0b want 0/1", a_cnt, a_data); end
    tick();
    n_checks++; if (a_serr !== 1'b0 || a_valid !== 1'b1) begin n_fail++; $display("FAIL zero_seed_after got err=%0b v=%0b want 0/1", a_serr, a_valid); end
  endtask

  task automatic test_drain_and_load();
    a_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (a_valid !== 1'b1 || a_cnt !== 32'd0) begin n_fail++; $display("FAIL drain_hold cycle %0d got v=%0b cnt=%0d want 1/0", i, a_valid, a_cnt); end
    end
    a_ready = 1;
    tick();
    a_ready = 0;
    n_checks++; if (a_valid !== 1'b0 || a_cnt !== 32'd1 || a_data !== 1'b0) begin n_fail++; $display("FAIL drain_done got v=%0b cnt=%0d d=%0b want 0/1/0", a_valid, a_cnt, a_data); end
    tick();
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL drain_idle got %0b want 0", a_valid); end
    a_en = 1;
    tick();
    n_checks++; if (a_valid !== 1'b1 || a_data !== 1'b0) begin n_fail++; $display("FAIL restart got v=%0b d=%0b want 1/0", a_valid, a_data); end
    // Load (seed 11) coincident with a fire of state 2.
    a_seed = 4'd11; a_ld = 1; a_ready = 1;
    tick();
    a_ld = 0; a_ready = 0;
    n_checks++; if (a_cnt !== 32'd0 || a_valid !== 1'b0) begin n_fail++; $display("FAIL load_fire got cnt=%0d v=%0b want 0/0", a_cnt, a_valid); end
    n_checks++; if (a_data !== 1'b1 || a_serr !== 1'b0 || a_wrap !== 1'b0) begin n_fail++; $display("FAIL load_fire_state got d=%0b err=%0b wrap=%0b want 1/0/0", a_data, a_serr, a_wrap); end
    tick();
    a_ready = 1;
    tick();
    // 11 (1011) shifts to 7 (0111).
    n_checks++; if (a_cnt !== 32'd1 || a_data !== 1'b1 || a_valid !== 1'b1) begin n_fail++; $display("FAIL load_then_fire got cnt=%0d d=%0b v=%0b want 1/1/1", a_cnt, a_data, a_valid); end
    a_en = 0;
    tick();
    a_ready = 0;
  endtask

  task automatic test_long_run_w32();
    logic [31:0] model;
    logic [15:0] mcnt;
    int fires, cycles;
    logic v, r, prev_stall;
    c_seed = 32'hACE1_2345; c_ld = 1;
    tick();
    c_ld = 0;
    n_checks++; if (c_data !== 8'h45 || c_valid !== 1'b0 || c_serr !== 1'b0) begin n_fail++; $display("FAIL c_load got d=%0h v=%0b err=%0b want 45/0/0", c_data, c_valid, c_serr); end
    model = 32'hACE1_2345; mcnt = '0; fires = 0; cycles = 0; prev_stall = 0;
    c_en = 1;
    while (fires < 1000 && cycles < 5000) begin
      r = ($urandom_range(0, 3) != 0);
      c_ready = r;
      v = c_valid;
      if (prev_stall) begin
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL c_valid_dropped beat %0d got %0b want 1", fires, v); end
      end
      if (v) begin
        n_checks++; if (c_data !== model[7:0]) begin n_fail++; $display("FAIL c_data beat %0d got %0h want %0h", fires, c_data, model[7:0]); end
      end
      n_checks++; if (c_cnt !== mcnt) begin n_fail++; $display("FAIL c_cnt beat %0d got %0d want %0d", fires, c_cnt, mcnt); end
      tick();
      cycles++;
      prev_stall = v && !r;
      if (v && r) begin
        model = adv32x8(model);
        mcnt  = mcnt + 16'd1;
        fires++;
      end
    end
    n_checks++; if (fires < 1000) begin n_fail++; $display("FAIL c_timeout got %0d beats want 1000", fires); end
    c_ready = 1;
    #3 reset = 1'b0;
    #1;
    n_checks++; if ({c_valid, c_serr, c_wrap} !== 3'b000) begin n_fail++; $display("FAIL c_async_reset_flags got %b want 000", {c_valid, c_serr, c_wrap}); end
    n_checks++; if (c_data !== 8'h01 || c_cnt !== 16'd0) begin n_fail++; $display("FAIL c_async_reset_state got d=%0h cnt=%0d want 01/0", c_data, c_cnt); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_checks++; if (c_valid !== 1'b1 || c_data !== 8'h01) begin n_fail++; $display("FAIL c_after_reset got v=%0b d=%0h want 1/01", c_valid, c_data); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    test_reset();
    test_serial_w4();
    test_multi_step();
    test_backpressure();
    test_seed_zero();
    test_drain_and_load();
    test_long_run_w32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
